// File: rtl/g3_upd_pkg.sv
// Shared definitions for the G3 hash-chain update engine: widths, entry layout,
// opcodes, status codes and FSM states.
package g3_upd_pkg;

  localparam int unsigned INDEX_BIT_LEN    = 11;
  localparam int unsigned ENTRY_DATA_WIDTH = 98;
  localparam int unsigned COMMAND_BIT_LEN  = 2;
  localparam int unsigned TABLE_ENTRY_SIZE = 2047;
  localparam int unsigned FREE_BASE        = 1024;
  localparam int unsigned MAX_WALK         = 64;
  localparam int unsigned IP_W             = 32;
  localparam int unsigned STATUS_W         = 3;
  localparam int unsigned HOP_W            = 7;
  localparam int unsigned ALLOC_W          = 12;

  localparam logic [INDEX_BIT_LEN-1:0] NULL_IDX = 11'h7FF;
  localparam logic [INDEX_BIT_LEN-1:0] TOMB_ID  = 11'h7FF;

  localparam logic [COMMAND_BIT_LEN-1:0] OP_INSERT = 2'b01;
  localparam logic [COMMAND_BIT_LEN-1:0] OP_DELETE = 2'b10;

  localparam logic [STATUS_W-1:0] ST_OK        = 3'b000;
  localparam logic [STATUS_W-1:0] ST_NOT_FOUND = 3'b001;
  localparam logic [STATUS_W-1:0] ST_FULL      = 3'b010;
  localparam logic [STATUS_W-1:0] ST_LOOP      = 3'b011;
  localparam logic [STATUS_W-1:0] ST_DUP       = 3'b100;
  localparam logic [STATUS_W-1:0] ST_BADOP     = 3'b101;

  // Table entry: [97:87] next, [86:76] ruleID, [69:38] dstIP, [31:0] srcIP
  typedef struct packed {
    logic [INDEX_BIT_LEN-1:0] next;
    logic [INDEX_BIT_LEN-1:0] rule_id;
    logic [5:0]               pad1;
    logic [IP_W-1:0]          dst_ip;
    logic [5:0]               pad0;
    logic [IP_W-1:0]          src_ip;
  } entry_t;

  typedef enum logic [2:0] {
    S_IDLE, S_RD, S_WT, S_EVAL, S_WR_NEW, S_WR_LINK, S_WR_ONE, S_RSP
  } state_e;

  function automatic entry_t make_entry(input logic [INDEX_BIT_LEN-1:0] next,
                                        input logic [INDEX_BIT_LEN-1:0] rule_id,
                                        input logic [IP_W-1:0]          dst_ip,
                                        input logic [IP_W-1:0]          src_ip);
    entry_t e;
    e.next    = next;
    e.rule_id = rule_id;
    e.pad1    = '0;
    e.dst_ip  = dst_ip;
    e.pad0    = '0;
    e.src_ip  = src_ip;
    return e;
  endfunction

endpackage

// File: rtl/g3_update_ctrl_if.sv
// Command, table-port and status bundle of the G3 update engine.
interface g3_update_ctrl_if;
  import g3_upd_pkg::*;

  logic                        cmd_valid;
  logic                        cmd_ready;
  logic [COMMAND_BIT_LEN-1:0]  cmd_op;
  logic [INDEX_BIT_LEN-1:0]    cmd_head;
  logic [IP_W-1:0]             cmd_src_ip;
  logic [IP_W-1:0]             cmd_dst_ip;
  logic [INDEX_BIT_LEN-1:0]    cmd_rule_id;
  logic                        tbl_re;
  logic                        tbl_we;
  logic [INDEX_BIT_LEN-1:0]    tbl_index;
  logic [ENTRY_DATA_WIDTH-1:0] tbl_din;
  logic [ENTRY_DATA_WIDTH-1:0] tbl_rdata;
  logic                        rsp_valid;
  logic [STATUS_W-1:0]         rsp_status;

  // Update engine side
  modport master (
    input  cmd_valid, cmd_op, cmd_head, cmd_src_ip, cmd_dst_ip, cmd_rule_id, tbl_rdata,
    output cmd_ready, tbl_re, tbl_we, tbl_index, tbl_din, rsp_valid, rsp_status
  );

  // Command source / table side
  modport slave (
    output cmd_valid, cmd_op, cmd_head, cmd_src_ip, cmd_dst_ip, cmd_rule_id, tbl_rdata,
    input  cmd_ready, tbl_re, tbl_we, tbl_index, tbl_din, rsp_valid, rsp_status
  );
endinterface

// File: rtl/g3_upd_alloc.sv
// Overflow-region allocator: bump pointer from FREE_BASE, full once past the table end.
module g3_upd_alloc
  import g3_upd_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     bump,
  output logic [INDEX_BIT_LEN-1:0] alloc_idx,
  output logic                     full_c
);

  logic [ALLOC_W-1:0] alloc_ptr_q, alloc_ptr_d;

  // Pointer advances only on a completed append and never past the full point
  always_comb begin
    full_c      = alloc_ptr_q > ALLOC_W'(TABLE_ENTRY_SIZE);
    alloc_ptr_d = alloc_ptr_q;
    if (bump && !full_c) alloc_ptr_d = alloc_ptr_q + ALLOC_W'(1);
  end

  // Pointer register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) alloc_ptr_q <= ALLOC_W'(FREE_BASE);
    else     alloc_ptr_q <= alloc_ptr_d;
  end

  assign alloc_idx = alloc_ptr_q[INDEX_BIT_LEN-1:0];

endmodule

// File: rtl/g3_update_ctrl.sv
// G3 hash-chain table writer: walks a bucket chain and inserts/deletes rules.
// Optional build macro G3_UPD_DUP_CHECK_EN: inserts walk the whole chain, report
// DUP on a live match, and reuse the first tombstone only at chain end.
module g3_update_ctrl
  import g3_upd_pkg::*;
(
  input logic              clk,
  input logic              rst,
  g3_update_ctrl_if.master bus
);

  state_e                     state_q, state_d;
  logic [INDEX_BIT_LEN-1:0]   cur_q, cur_d;
  logic [HOP_W-1:0]           hops_q, hops_d;
  logic [COMMAND_BIT_LEN-1:0] op_q, op_d;
  logic [IP_W-1:0]            src_q, src_d, dst_q, dst_d;
  logic [INDEX_BIT_LEN-1:0]   rid_q, rid_d;
  entry_t                     entry_q, entry_d;
`ifdef G3_UPD_DUP_CHECK_EN
  logic                       tomb_vld_q, tomb_vld_d;
  logic [INDEX_BIT_LEN-1:0]   tomb_idx_q, tomb_idx_d;
  logic [INDEX_BIT_LEN-1:0]   tomb_next_q, tomb_next_d;
`endif

  logic                       cmd_ready_q, cmd_ready_d;
  logic                       tbl_re_q, tbl_re_d, tbl_we_q, tbl_we_d;
  logic [INDEX_BIT_LEN-1:0]   tbl_index_q, tbl_index_d;
  entry_t                     tbl_din_q, tbl_din_d;
  logic                       rsp_valid_q, rsp_valid_d;
  logic [STATUS_W-1:0]        rsp_status_q, rsp_status_d;

  logic                       bump_c, full_c;
  logic [INDEX_BIT_LEN-1:0]   alloc_idx;
  logic                       live_c, at_end_c, match_c, follow_c, alloc_c;

  g3_upd_alloc u_alloc (
    .clk       (clk),
    .rst       (rst),
    .bump      (bump_c),
    .alloc_idx (alloc_idx),
    .full_c    (full_c)
  );

  // Next-state and registered-output decode
  always_comb begin
    state_d      = state_q;
    cur_d        = cur_q;
    hops_d       = hops_q;
    op_d         = op_q;
    src_d        = src_q;
    dst_d        = dst_q;
    rid_d        = rid_q;
    entry_d      = entry_q;
`ifdef G3_UPD_DUP_CHECK_EN
    tomb_vld_d   = tomb_vld_q;
    tomb_idx_d   = tomb_idx_q;
    tomb_next_d  = tomb_next_q;
`endif
    tbl_re_d     = 1'b0;
    tbl_we_d     = 1'b0;
    tbl_index_d  = tbl_index_q;
    tbl_din_d    = tbl_din_q;
    rsp_valid_d  = 1'b0;
    rsp_status_d = rsp_status_q;
    bump_c       = 1'b0;
    follow_c     = 1'b0;
    alloc_c      = 1'b0;
    live_c       = entry_q.rule_id != TOMB_ID;
    at_end_c     = entry_q.next == NULL_IDX;
    match_c      = live_c && (entry_q.src_ip == src_q) && (entry_q.dst_ip == dst_q);

    case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          op_d   = bus.cmd_op;
          src_d  = bus.cmd_src_ip;
          dst_d  = bus.cmd_dst_ip;
          rid_d  = bus.cmd_rule_id;
          cur_d  = bus.cmd_head;
          hops_d = '0;
`ifdef G3_UPD_DUP_CHECK_EN
          tomb_vld_d = 1'b0;
`endif
          if (bus.cmd_op == OP_INSERT || bus.cmd_op == OP_DELETE) begin
            state_d     = S_RD;
            tbl_re_d    = 1'b1;
            tbl_index_d = bus.cmd_head;
          end else begin
            state_d      = S_RSP;
            rsp_valid_d  = 1'b1;
            rsp_status_d = ST_BADOP;
          end
        end
      end
      S_RD: state_d = S_WT;
      S_WT: begin
        entry_d = entry_t'(bus.tbl_rdata);
        state_d = S_EVAL;
      end
      S_EVAL: begin
        if (op_q == OP_DELETE) begin
          if (match_c) begin
            state_d           = S_WR_ONE;
            tbl_we_d          = 1'b1;
            tbl_index_d       = cur_q;
            tbl_din_d         = entry_q;
            tbl_din_d.rule_id = TOMB_ID;
          end else if (at_end_c) begin
            state_d      = S_RSP;
            rsp_valid_d  = 1'b1;
            rsp_status_d = ST_NOT_FOUND;
          end else begin
            follow_c = 1'b1;
          end
        end else begin
`ifdef G3_UPD_DUP_CHECK_EN
          if (match_c) begin
            state_d      = S_RSP;
            rsp_valid_d  = 1'b1;
            rsp_status_d = ST_DUP;
          end else begin
            if (!tomb_vld_q && !live_c) begin
              tomb_vld_d  = 1'b1;
              tomb_idx_d  = cur_q;
              tomb_next_d = entry_q.next;
            end
            if (!at_end_c) begin
              follow_c = 1'b1;
            end else if (tomb_vld_d) begin
              state_d     = S_WR_ONE;
              tbl_we_d    = 1'b1;
              tbl_index_d = tomb_idx_d;
              tbl_din_d   = make_entry(tomb_next_d, rid_q, dst_q, src_q);
            end else begin
              alloc_c = 1'b1;
            end
          end
`else
          if (!live_c) begin
            state_d     = S_WR_ONE;
            tbl_we_d    = 1'b1;
            tbl_index_d = cur_q;
            tbl_din_d   = make_entry(entry_q.next, rid_q, dst_q, src_q);
          end else if (at_end_c) begin
            alloc_c = 1'b1;
          end else begin
            follow_c = 1'b1;
          end
`endif
        end

        // Step to the next chain entry unless the hop budget is spent
        if (follow_c) begin
          if (hops_q == HOP_W'(MAX_WALK - 1)) begin
            state_d      = S_RSP;
            rsp_valid_d  = 1'b1;
            rsp_status_d = ST_LOOP;
          end else begin
            cur_d       = entry_q.next;
            hops_d      = hops_q + HOP_W'(1);
            state_d     = S_RD;
            tbl_re_d    = 1'b1;
            tbl_index_d = entry_q.next;
          end
        end

        // Append a fresh entry from the overflow region
        if (alloc_c) begin
          if (full_c) begin
            state_d      = S_RSP;
            rsp_valid_d  = 1'b1;
            rsp_status_d = ST_FULL;
          end else begin
            state_d     = S_WR_NEW;
            tbl_we_d    = 1'b1;
            tbl_index_d = alloc_idx;
            tbl_din_d   = make_entry(NULL_IDX, rid_q, dst_q, src_q);
          end
        end
      end
      S_WR_NEW: begin
        state_d        = S_WR_LINK;
        tbl_we_d       = 1'b1;
        tbl_index_d    = cur_q;
        tbl_din_d      = entry_q;
        tbl_din_d.next = alloc_idx;
      end
      S_WR_LINK, S_WR_ONE: begin
        state_d      = S_RSP;
        rsp_valid_d  = 1'b1;
        rsp_status_d = ST_OK;
        bump_c       = state_q == S_WR_LINK;
      end
      S_RSP:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    cmd_ready_d = state_d == S_IDLE;
  end

  // State, context and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cur_q        <= '0;
      hops_q       <= '0;
      op_q         <= '0;
      src_q        <= '0;
      dst_q        <= '0;
      rid_q        <= '0;
      entry_q      <= '0;
`ifdef G3_UPD_DUP_CHECK_EN
      tomb_vld_q   <= 1'b0;
      tomb_idx_q   <= '0;
      tomb_next_q  <= '0;
`endif
      cmd_ready_q  <= 1'b1;
      tbl_re_q     <= 1'b0;
      tbl_we_q     <= 1'b0;
      tbl_index_q  <= '0;
      tbl_din_q    <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_status_q <= '0;
    end else begin
      state_q      <= state_d;
      cur_q        <= cur_d;
      hops_q       <= hops_d;
      op_q         <= op_d;
      src_q        <= src_d;
      dst_q        <= dst_d;
      rid_q        <= rid_d;
      entry_q      <= entry_d;
`ifdef G3_UPD_DUP_CHECK_EN
      tomb_vld_q   <= tomb_vld_d;
      tomb_idx_q   <= tomb_idx_d;
      tomb_next_q  <= tomb_next_d;
`endif
      cmd_ready_q  <= cmd_ready_d;
      tbl_re_q     <= tbl_re_d;
      tbl_we_q     <= tbl_we_d;
      tbl_index_q  <= tbl_index_d;
      tbl_din_q    <= tbl_din_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_status_q <= rsp_status_d;
    end
  end

  assign bus.cmd_ready  = cmd_ready_q;
  assign bus.tbl_re     = tbl_re_q;
  assign bus.tbl_we     = tbl_we_q;
  assign bus.tbl_index  = tbl_index_q;
  assign bus.tbl_din    = tbl_din_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_status = rsp_status_q;

endmodule

// File: tb/tb_g3_update_ctrl.sv
// Scoreboard bench for g3_update_ctrl: a table model answers reads one cycle
// after tbl_re; each command pushes its expected status, writes, read count and
// latency (cycle 1 = the accept cycle), and a monitor checks them at rsp_valid.
module tb_g3_update_ctrl;

  typedef struct {
    int          tag;
    logic [2:0]  st;
    int          nwr;
    int          nrd;   // -1: not checked
    int          lat;   // 0: not checked
    logic [10:0] i0;
    logic [97:0] d0;
    logic [10:0] i1;
    logic [97:0] d1;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  g3_update_ctrl_if ifc();
  g3_update_ctrl dut (.clk(clk), .rst(rst), .bus(ifc));

  // Table model
  logic [97:0] mem [0:2047];
  logic [97:0] rdata = '0;
  logic        pre_we = 1'b0;
  logic [10:0] pre_idx = '0;
  logic [97:0] pre_dat = '0;
  always @(posedge clk) begin
    if (pre_we)          mem[pre_idx] <= pre_dat;
    else if (ifc.tbl_we) mem[ifc.tbl_index] <= ifc.tbl_din;
    if (ifc.tbl_re)      rdata <= mem[ifc.tbl_index];
  end
  assign ifc.tbl_rdata = rdata;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  function automatic logic [97:0] mk(input logic [10:0] nx, input logic [10:0] id,
                                     input logic [31:0] dst, input logic [31:0] src);
    return {nx, id, 6'b0, dst, 6'b0, src};
  endfunction

  function automatic exp_t ex(input int tag, input logic [2:0] st, input int nwr, input int nrd,
                              input int lat, input logic [10:0] i0, input logic [97:0] d0,
                              input logic [10:0] i1, input logic [97:0] d1);
    exp_t e;
    e.tag = tag; e.st = st; e.nwr = nwr; e.nrd = nrd; e.lat = lat;
    e.i0 = i0; e.d0 = d0; e.i1 = i1; e.d1 = d1;
    return e;
  endfunction

  task automatic chk(input string nm, input int tag, input logic [97:0] act, input logic [97:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cmd%0d: got %0h expected %0h", nm, tag, act, exp);
    end
  endtask

  // Monitor: track per-command writes/reads, compare at each response
  int          cyc = 0, acc_cyc = 0, wr_n = 0, rd_n = 0;
  logic [10:0] wi [2];
  logic [97:0] wd [2];
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        wr_n = 0;
        rd_n = 0;
      end else begin
        if (ifc.cmd_valid && ifc.cmd_ready) begin
          acc_cyc = cyc;
          wr_n = 0;
          rd_n = 0;
        end
        if (ifc.tbl_re) rd_n++;
        if (ifc.tbl_we) begin
          if (wr_n < 2) begin
            wi[wr_n] = ifc.tbl_index;
            wd[wr_n] = ifc.tbl_din;
          end
          wr_n++;
        end
        if (ifc.rsp_valid) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_rsp: got status %0h expected no response", ifc.rsp_status);
          end else begin
            exp_t e;
            e = sb.pop_front();
            chk("status", e.tag, 98'(ifc.rsp_status), 98'(e.st));
            chk("write_count", e.tag, 98'(wr_n), 98'(e.nwr));
            if (e.nrd >= 0) chk("read_count", e.tag, 98'(rd_n), 98'(e.nrd));
            if (e.lat > 0)  chk("latency", e.tag, 98'(cyc - acc_cyc + 1), 98'(e.lat));
            if (e.nwr >= 1 && wr_n >= 1) begin
              chk("wr0_index", e.tag, 98'(wi[0]), 98'(e.i0));
              chk("wr0_data", e.tag, wd[0], e.d0);
            end
            if (e.nwr >= 2 && wr_n >= 2) begin
              chk("wr1_index", e.tag, 98'(wi[1]), 98'(e.i1));
              chk("wr1_data", e.tag, wd[1], e.d1);
            end
          end
        end
      end
    end
  end

  task automatic poke(input logic [10:0] idx, input logic [97:0] d);
    pre_idx = idx;
    pre_dat = d;
    pre_we  = 1'b1;
    @(posedge clk); #1;
    pre_we  = 1'b0;
  endtask

  task automatic send(input logic [1:0] op, input logic [10:0] head, input logic [31:0] src,
                      input logic [31:0] dst, input logic [10:0] rid);
    ifc.cmd_op = op; ifc.cmd_head = head; ifc.cmd_src_ip = src;
    ifc.cmd_dst_ip = dst; ifc.cmd_rule_id = rid;
    ifc.cmd_valid = 1'b1;
    @(posedge clk); #1;
    ifc.cmd_valid = 1'b0;
  endtask

  // Bounded wait until every pushed expectation has been answered and the engine is idle
  task automatic wait_idle(input int tag);
    bit done;
    done = 1'b0;
    for (int n = 0; n < 600 && !done; n++) begin
      if (sb.size() == 0 && ifc.cmd_ready) done = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL timeout cmd%0d: got no response within 600 cycles expected a response", tag);
      sb.delete();
    end
  endtask

  task automatic chk_reset_outs(input int tag);
    chk("rst_cmd_ready", tag, 98'(ifc.cmd_ready), 98'(1));
    chk("rst_tbl_re", tag, 98'(ifc.tbl_re), 98'(0));
    chk("rst_tbl_we", tag, 98'(ifc.tbl_we), 98'(0));
    chk("rst_tbl_index", tag, 98'(ifc.tbl_index), 98'(0));
    chk("rst_tbl_din", tag, ifc.tbl_din, 98'(0));
    chk("rst_rsp_valid", tag, 98'(ifc.rsp_valid), 98'(0));
    chk("rst_rsp_status", tag, 98'(ifc.rsp_status), 98'(0));
  endtask

  localparam logic [1:0]  INS = 2'b01, DEL = 2'b10;
  localparam logic [10:0] NUL = 11'h7FF;
  localparam logic [31:0] A1 = 32'h0A000001, B1 = 32'h0B000001;
  localparam logic [31:0] A2 = 32'h0A000002, B2 = 32'h0B000002;
  localparam logic [31:0] A3 = 32'h0A000003, B3 = 32'h0B000003;
  localparam logic [31:0] A4 = 32'h0A000004, B4 = 32'h0B000004;

  initial begin
    logic [97:0] prev, newe, link;
    logic [10:0] head, idx;

    ifc.cmd_valid = 1'b0; ifc.cmd_op = '0; ifc.cmd_head = '0;
    ifc.cmd_src_ip = '0; ifc.cmd_dst_ip = '0; ifc.cmd_rule_id = '0;
    @(negedge clk); @(negedge clk);
    chk_reset_outs(0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Head 5 is a tombstone at chain end: reuse in place
    poke(11'd5, mk(NUL, NUL, 32'h0, 32'h0));
    sb.push_back(ex(1, 3'b000, 1, 1, 6, 11'd5, mk(NUL, 11'd3, B1, A1), '0, '0));
    send(INS, 11'd5, A1, B1, 11'd3); wait_idle(1);

    // Live head at chain end: append at 1024, link head
    sb.push_back(ex(2, 3'b000, 2, 1, 0, 11'd1024, mk(NUL, 11'd4, B2, A2), 11'd5, mk(11'd1024, 11'd3, B1, A1)));
    send(INS, 11'd5, A2, B2, 11'd4); wait_idle(2);

    // Chain 5->1024->NULL: append at 1025, relink 1024
    sb.push_back(ex(3, 3'b000, 2, 2, 0, 11'd1025, mk(NUL, 11'd5, B3, A3), 11'd1024, mk(11'd1025, 11'd4, B2, A2)));
    send(INS, 11'd5, A3, B3, 11'd5); wait_idle(3);

    // Delete the rule at 1024: tombstone, next kept
    sb.push_back(ex(4, 3'b000, 1, 2, 9, 11'd1024, mk(11'd1025, NUL, B2, A2), '0, '0));
    send(DEL, 11'd5, A2, B2, 11'd0); wait_idle(4);

`ifdef G3_UPD_DUP_CHECK_EN
    // Re-insert the rule living at 1025
    sb.push_back(ex(5, 3'b100, 0, 3, 0, '0, '0, '0, '0));
    send(INS, 11'd5, A3, B3, 11'd5); wait_idle(5);
    // New rule: full walk, then reuse the tombstone at 1024 with its next
    sb.push_back(ex(6, 3'b000, 1, 3, 12, 11'd1024, mk(11'd1025, 11'd6, B4, A4), '0, '0));
    send(INS, 11'd5, A4, B4, 11'd6); wait_idle(6);
    sb.push_back(ex(7, 3'b001, 0, 3, 0, '0, '0, '0, '0));
`else
    // Tombstone at 1024 is reused immediately
    sb.push_back(ex(5, 3'b000, 1, 2, 9, 11'd1024, mk(11'd1025, 11'd5, B3, A3), '0, '0));
    send(INS, 11'd5, A3, B3, 11'd5); wait_idle(5);
    // No tombstone left: append at 1026 after 1025
    sb.push_back(ex(6, 3'b000, 2, 3, 0, 11'd1026, mk(NUL, 11'd6, B4, A4), 11'd1025, mk(11'd1026, 11'd5, B3, A3)));
    send(INS, 11'd5, A4, B4, 11'd6); wait_idle(6);
    sb.push_back(ex(7, 3'b001, 0, 4, 0, '0, '0, '0, '0));
`endif
    // Delete of a rule that is not in the chain
    send(DEL, 11'd5, 32'h0A0000FF, 32'h0B0000FF, 11'd0); wait_idle(7);

    // Bad opcodes: no table access
    sb.push_back(ex(8, 3'b101, 0, 0, 0, '0, '0, '0, '0));
    send(2'b11, 11'd5, A1, B1, 11'd1); wait_idle(8);
    sb.push_back(ex(9, 3'b101, 0, 0, 0, '0, '0, '0, '0));
    send(2'b00, 11'd5, A1, B1, 11'd1); wait_idle(9);

    // Looping chain 5->6->5
    poke(11'd5, mk(11'd6, 11'd3, B1, A1));
    poke(11'd6, mk(11'd5, 11'd9, 32'h0, 32'h0));
    sb.push_back(ex(10, 3'b011, 0, -1, 0, '0, '0, '0, '0));
    send(INS, 11'd5, 32'h0A000010, 32'h0B000010, 11'd7); wait_idle(10);

    // Reset in the middle of a walk
    send(INS, 11'd5, 32'h0A000011, 32'h0B000011, 11'd8);
    repeat (20) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk_reset_outs(11);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_cmd_ready", 11, 98'(ifc.cmd_ready), 98'(1));
    chk("post_rst_rsp_valid", 11, 98'(ifc.rsp_valid), 98'(0));

    // Fill the overflow region: each new entry becomes the next head
    poke(11'd10, mk(NUL, 11'd0, 32'h0, 32'h0));
    prev = mk(NUL, 11'd0, 32'h0, 32'h0);
    head = 11'd10;
    for (int k = 0; k < 1024; k++) begin
      idx  = 11'(1024 + k);
      newe = mk(NUL, 11'(k), 32'h0D000000, 32'h0C000000 + 32'(k));
      link = prev;
      link[97:87] = idx;
      sb.push_back(ex(100 + k, 3'b000, 2, 1, 0, idx, newe, head, link));
      send(INS, head, 32'h0C000000 + 32'(k), 32'h0D000000, 11'(k));
      wait_idle(100 + k);
      prev = newe;
      head = idx;
    end
    // Allocator exhausted
    sb.push_back(ex(2000, 3'b010, 0, 1, 0, '0, '0, '0, '0));
    send(INS, 11'd2047, 32'h0E000000, 32'h0F000000, 11'd1); wait_idle(2000);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #(600000);
    $display("FAIL watchdog: got no end of run expected completion within 60000 cycles");
    $fatal(1);
  end

endmodule
